// File: rtl/loop_iter_controller.sv
// ---------------------------------------------------------------------------
// loop_iter_controller
//
// Nested-loop iteration controller feeding the strided address walker.
// Holds a table of per-loop "iteration count minus one" values written by
// the decoder, steps a chain of nested counters once per non-stalled cycle
// of a walk, and presents the carry vector (iter_done) the walker consumes.
//
// Loop 0 is the outermost loop and loop N-1 the innermost. iter_done[N] is
// the step strobe; iter_done[i] is high when loop i wraps on this step, so
// iter_done[0] marks the final step of the walk.
//
// iter_done/step_v are combinational from the registered counters, the
// state and the same-cycle stall, because the walker samples iter_done and
// stall in the same cycle.
// ---------------------------------------------------------------------------
module loop_iter_controller #(
   parameter int LOOP_ID_W     = 5,
   parameter int NUM_MAX_LOOPS = 32'd1 << LOOP_ID_W,
   parameter int ITER_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     block_done,
   input  logic                     stall,
   input  logic                     cfg_loop_iter_v,
   input  logic [LOOP_ID_W-1:0]     cfg_loop_id,
   input  logic [ITER_W-1:0]        cfg_loop_iter,
   output logic [NUM_MAX_LOOPS:0]   iter_done,
   output logic                     step_v,
   output logic                     busy,
   output logic                     done
);

   // FSM encoding kept as plain constants for compatibility with older tools.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]               state_r;
   logic [0:0]               state_nxt_s;

   // Iteration table (count minus one per loop) and the nested counters.
   logic [ITER_W-1:0]        iter_last_r [NUM_MAX_LOOPS];
   logic [ITER_W-1:0]        cnt_r       [NUM_MAX_LOOPS];

   logic                     busy_s;
   logic                     idle_s;
   logic                     step_s;
   logic                     cfg_id_ok_s;
   logic                     carry_s;
   logic [NUM_MAX_LOOPS-1:0] match_s;
   logic [NUM_MAX_LOOPS:0]   iter_done_s;
   logic                     done_r;

   assign busy_s = (state_r == ST_RUN);
   assign idle_s = (state_r == ST_IDLE);

   // A stalled cycle or an idle controller never steps.
   assign step_s = busy_s & ~stall;

   // Guard against loop ids beyond the table when the table is narrower
   // than the id field allows.
   assign cfg_id_ok_s = (int'(cfg_loop_id) < NUM_MAX_LOOPS);

   // Per-loop "counter sits on its last iteration" flags.
   always_comb begin
      match_s = '0;
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
         match_s[i] = (cnt_r[i] == iter_last_r[i]);
      end
   end

   // Carry chain from the innermost loop outward: a loop completes only when
   // every loop inside it also completes on this step.
   always_comb begin
      iter_done_s                = '0;
      carry_s                    = step_s;
      iter_done_s[NUM_MAX_LOOPS] = step_s;
      for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
         carry_s        = carry_s & match_s[i];
         iter_done_s[i] = carry_s;
      end
   end

   // Next-state logic: start only from IDLE, return when the walk completes.
   // A start coinciding with completion is ignored because the FSM is still
   // in RUN during that cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (iter_done_s[0]) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Iteration table: only changes in IDLE; block_done beats a same-cycle
   // write so the block boundary always leaves a clean all-zero table.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
            iter_last_r[i] <= '0;
         end
      end else if (idle_s && block_done) begin
         for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
            iter_last_r[i] <= '0;
         end
      end else if (idle_s && cfg_loop_iter_v && cfg_id_ok_s) begin
         iter_last_r[cfg_loop_id] <= cfg_loop_iter;
      end
   end

   // Nested counters: wrap on own completion, advance when the next inner
   // loop completes, otherwise hold. Held at zero whenever idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
            cnt_r[i] <= '0;
         end
      end else if (!busy_s) begin
         for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
            cnt_r[i] <= '0;
         end
      end else if (step_s) begin
         for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
            if (iter_done_s[i]) begin
               cnt_r[i] <= '0;
            end else if (iter_done_s[i+1]) begin
               cnt_r[i] <= cnt_r[i] + ITER_W'(1);
            end
         end
      end
   end

   // Completion pulse for the decoder, one cycle after the final step.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_r <= 1'b0;
      end else begin
         done_r <= iter_done_s[0];
      end
   end

   assign iter_done = iter_done_s;
   assign step_v    = iter_done_s[NUM_MAX_LOOPS];
   assign busy      = busy_s;
   assign done      = done_r;

endmodule

// File: tb/tb_loop_iter_controller.sv
// ---------------------------------------------------------------------------
// Directed, table-driven bench for loop_iter_controller with 4 loops.
// Each table row is one clock cycle: inputs are driven after the falling
// edge and the outputs for that same cycle are compared 1ns later.
// ---------------------------------------------------------------------------
module tb_loop_iter_controller;

   localparam int LID_W = 2;
   localparam int NL    = 4;
   localparam int IW    = 16;

   logic            clk = 1'b0;
   logic            reset, start, block_done, stall, cfg_loop_iter_v;
   logic [LID_W-1:0] cfg_loop_id;
   logic [IW-1:0]   cfg_loop_iter;
   logic [NL:0]     iter_done;
   logic            step_v, busy, done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic            rst;
      logic            st;
      logic            sl;
      logic            bd;
      logic            cv;
      logic [LID_W-1:0] id;
      logic [IW-1:0]   it;
      logic            chk;
      logic [NL:0]     e_id;
      logic            e_busy;
      logic            e_done;
   } vec_t;

   vec_t vecs[$];

   loop_iter_controller #(
      .LOOP_ID_W    (LID_W),
      .NUM_MAX_LOOPS(NL),
      .ITER_W       (IW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .block_done     (block_done),
      .stall          (stall),
      .cfg_loop_iter_v(cfg_loop_iter_v),
      .cfg_loop_id    (cfg_loop_id),
      .cfg_loop_iter  (cfg_loop_iter),
      .iter_done      (iter_done),
      .step_v         (step_v),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic st, input logic sl, input logic bd,
                      input logic cv, input logic [LID_W-1:0] id, input logic [IW-1:0] it,
                      input logic chk, input logic [NL:0] e_id, input logic e_busy, input logic e_done);
      vec_t v;
      v.rst = rst; v.st = st; v.sl = sl; v.bd = bd; v.cv = cv; v.id = id; v.it = it;
      v.chk = chk; v.e_id = e_id; v.e_busy = e_busy; v.e_done = e_done;
      vecs.push_back(v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      logic seen_done;
      logic [NL:0] last_id;

      reset = 1'b1; start = 1'b0; block_done = 1'b0; stall = 1'b0;
      cfg_loop_iter_v = 1'b0; cfg_loop_id = '0; cfg_loop_iter = '0;

      // rst st sl bd cv id it  chk iter_done busy done
      // A: reset, program {0,0,1,2}, unstalled 6-step walk
      add(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b0,5'h00,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,16'd1, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd3,16'd2, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h18,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      // B: same walk, 3-cycle stalls before steps 2 and 5 (12 busy cycles)
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h18,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      // C: config writes, block_done and start during RUN are all ignored
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd3,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,16'd0, 1'b1,5'h18,1'b1,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      // next walk sees the unchanged table; start on the final step is ignored,
      // start in the done cycle is accepted
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h18,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      // D: reset on the 4th step, no done; all-zero table gives one step
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h18,1'b1,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      // E: program {0,0,1,2}, block_done (with a lost same-cycle write) clears
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,16'd1, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd3,16'd2, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b1,1'b1,2'd1,16'd3, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);
      // F: fresh config (loop 3 = 2 iterations) completes normally
      add(1'b0,1'b0,1'b0,1'b0,1'b1,2'd3,16'd1, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h10,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h1F,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'd0, 1'b1,5'h00,1'b0,1'b1);

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         reset           = vecs[k].rst;
         start           = vecs[k].st;
         stall           = vecs[k].sl;
         block_done      = vecs[k].bd;
         cfg_loop_iter_v = vecs[k].cv;
         cfg_loop_id     = vecs[k].id;
         cfg_loop_iter   = vecs[k].it;
         #1;
         if (vecs[k].chk) begin
            check("iter_done", k, 32'(iter_done), 32'(vecs[k].e_id));
            check("step_v",    k, 32'(step_v),    32'(vecs[k].e_id[NL]));
            check("busy",      k, 32'(busy),      32'(vecs[k].e_busy));
            check("done",      k, 32'(done),      32'(vecs[k].e_done));
         end
      end

      // Long stall right after start, then a 4-step walk on loop 3.
      @(negedge clk);
      reset = 1'b0; start = 1'b0; stall = 1'b0; block_done = 1'b0;
      cfg_loop_iter_v = 1'b1; cfg_loop_id = 2'd3; cfg_loop_iter = 16'd3;
      @(negedge clk);
      cfg_loop_iter_v = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; stall = 1'b1;
      repeat (10) begin
         #1;
         check("stall_iter_done", 100, 32'(iter_done), 32'h0);
         check("stall_busy",      100, 32'(busy),      32'h1);
         @(negedge clk);
      end
      stall = 1'b0;
      steps = 0; seen_done = 1'b0; last_id = '0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         #1;
         if (step_v) begin
            steps++;
            last_id = iter_done;
         end
         if (done) begin
            seen_done = 1'b1;
         end
         @(negedge clk);
      end
      check("long_done_seen", 101, 32'(seen_done), 32'h1);
      check("long_step_count", 101, 32'(steps), 32'd4);
      check("long_last_carry", 101, 32'(last_id), 32'h1F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/loop_iter_controller.md
# loop_iter_controller

Nested-loop iteration controller that sits directly upstream of the strided memory address walker. It holds a per-loop iteration count table written by the instruction decoder, steps a chain of nested counters once per non-stalled cycle after `start`, and drives the `iter_done` carry vector the walker consumes. It also provides the walker's `start`/`block_done`-aligned control and a completion pulse back to the decoder.

## Interface
- `LOOP_ID_W`, 5: loop index width.
- `NUM_MAX_LOOPS`, 1<<LOOP_ID_W: number of nested loops N; loop 0 outermost, loop N-1 innermost.
- `ITER_W`, 16: iteration count width; table stores count minus one.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a walk; accepted only in IDLE.
- `block_done` in 1: end of instruction block; in IDLE, clears the iteration table to all zeros (every loop runs 1 iteration).
- `stall` in 1: downstream backpressure; suppresses stepping that cycle.
- `cfg_loop_iter_v` in 1: table write strobe; honoured only in IDLE.
- `cfg_loop_id` in LOOP_ID_W: loop index written.
- `cfg_loop_iter` in ITER_W: iteration count minus one for that loop.
- `iter_done` out N+1: carry vector to walker. Bit N is the step strobe. Bit i (i<N) means loop i completes on this step. Bit 0 means the walk completes.
- `step_v` out 1: equals `iter_done[N]`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse the cycle after the final step.

## Operation
- FSM states: IDLE, RUN.
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on the cycle `iter_done[0]` is high.
  - `start` in RUN is ignored.
  - A `start` in the same cycle the walk completes is ignored.
- Table `iter_last[0..N-1]`, ITER_W each:
  - Written on `cfg_loop_iter_v` in IDLE: `iter_last[cfg_loop_id] <= cfg_loop_iter`.
  - Writes and `block_done` in RUN are dropped.
  - If `block_done` and `cfg_loop_iter_v` arrive in the same IDLE cycle, `block_done` wins (table cleared, write lost).
- Counters `cnt[0..N-1]`, ITER_W each, all zero in IDLE.
- Combinational chain:
  - `step = busy & ~stall`.
  - `iter_done[N] = step`.
  - For i from N-1 down to 0: `iter_done[i] = iter_done[i+1] & (cnt[i] == iter_last[i])`.
  - `iter_done` is all zeros when stalled or in IDLE.
- Counter update on each cycle with `step`, for each i:
  - If `iter_done[i]`: `cnt[i] <= 0` (wrap).
  - Else if `iter_done[i+1]`: `cnt[i] <= cnt[i]+1`.
  - Else hold.
- Completion: `iter_done[0]` high means all counters wrap to 0, state returns to IDLE, and `done` is registered high for the next cycle only.
- Total steps per walk = product over i of (`iter_last[i]`+1). Unused loops keep `iter_last`=0 and are transparent to the chain.
- Counter compare is exact equality. No overflow is possible because wrap occurs at `iter_last`.

## Timing
- Reset values:
  - State IDLE.
  - `cnt` all 0, `iter_last` all 0.
  - `busy`=0, `done`=0, `iter_done`=0, `step_v`=0.
- `start` at cycle t gives `busy`=1 at t+1. The first possible step (`iter_done[N]`=1) is at t+1 if `stall`=0.
- `iter_done` and `step_v` are combinational from registered `cnt`, state and the same-cycle `stall`. This aligns with the walker, which samples `iter_done` and `stall` in the same cycle.
- Stall held any number of cycles: counters and state are frozen, `iter_done`=0. The first unstalled cycle resumes exactly where the walk left off.
- Final step at cycle f: `busy`=0 and `done`=1 at f+1, `done`=0 at f+2. The earliest next `start` is accepted at f+1.
- Reset mid-RUN: at the next edge the state is IDLE, counters are 0, the table is cleared, and no `done` is issued.

## Test plan
- N=4, `iter_last`={0,0,1,2} (loops 2,3 = 2×3), `start`, no stall:
  - Six steps with `iter_done` = 0x10, 0x10, 0x18, 0x10, 0x10, 0x1F.
  - `done` pulses the cycle after 0x1F.
  - `busy` high for exactly 6 cycles.
- Same config, `stall` high on steps 2 and 5 for 3 cycles each:
  - `iter_done`=0 during stalls.
  - The step sequence is identical to the unstalled case; total busy = 12 cycles.
- Table all zero (after reset), `start`: a single step with `iter_done`=0x1F, then `done` one cycle later.
- Config writes and `block_done` asserted during RUN:
  - The walk uses the old table; the next walk uses the unchanged table.
  - `start` during RUN does not restart the counters.
- `block_done` in IDLE after programming {0,0,1,2}, then `start`: a single-step walk (0x1F).
- Reset asserted on the 4th step of the first scenario: next cycle `busy`=0 and `iter_done`=0, no `done` pulse. A fresh config plus `start` completes normally.
